fetch_unit: RTL and testbench

- PC-generation and instruction-latch stage of the multi-cycle CPU.
- Sits between next-PC control and decode. Drives pc_out to the combinational instruction memory and receives instr_in in the same cycle.
- Latches that word into a one-entry instruction register (IR) offered to decode under a valid/ready handshake.
- Applies branch/jump/jr redirects, halts and fault detection.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC generation and one-entry instruction register for the multi-cycle CPU.
// Handles redirects (branch/jump/jr), halt, and sticky fetch faults.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic        fault,
    output logic [31:0] fetch_count
);
    // state   | meaning
    // RUN     | fetching sequentially, one word per load
    // BUBBLE  | single empty slot after a taken redirect
    // HALTED  | no more loads until reset
    typedef enum logic [1:0] {RUN, BUBBLE, HALTED} state_t;
    state_t state;

    localparam logic [31:0] DEPTH_W = 32'(IM_DEPTH);

    logic        transfer;
    logic        load;
    logic [31:0] ir_pc_plus4;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic        target_ok;
    logic        seq_ok;

    always_comb begin
        transfer      = ir_valid & ir_ready;
        load          = !ir_valid | transfer;
        ir_pc_plus4   = ir_pc + 32'd4;
        pc_plus4      = pc_out + 32'd4;
        branch_target = ir_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
        jump_target   = {ir_pc_plus4[31:28], jump_index, 2'b00};
        case (redirect_sel)
            2'b00:   target = branch_target;
            2'b01:   target = jump_target;
            default: target = jr_target;
        endcase
        target_ok = (target[1:0] == 2'b00) && ({2'b00, target[31:2]} < DEPTH_W)
                    && (redirect_sel != 2'b11);
        seq_ok    = {2'b00, pc_plus4[31:2]} < DEPTH_W;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_out      <= RESET_PC;
            ir_out      <= 32'd0;
            ir_pc       <= 32'd0;
            ir_valid    <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                RUN, BUBBLE: begin
                    if (transfer && redirect_valid) begin
                        // the word at pc_out is wrong-path and is dropped
                        ir_valid <= 1'b0;
                        if (target_ok) begin
                            pc_out <= target;
                            state  <= halt ? HALTED : BUBBLE;
                        end else begin
                            fault <= 1'b1;
                            state <= HALTED;
                        end
                    end else if (halt) begin
                        if (transfer) ir_valid <= 1'b0;
                        state <= HALTED;
                    end else if (load) begin
                        ir_out      <= instr_in;
                        ir_pc       <= pc_out;
                        ir_valid    <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                        if (seq_ok) begin
                            pc_out <= pc_plus4;
                            state  <= RUN;
                        end else begin
                            fault <= 1'b1;
                            state <= HALTED;
                        end
                    end
                end
                default: begin
                    if (transfer) ir_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed checks of fetch_unit against a behavioural model
// that tracks the architectural fetch state cycle by cycle.
module tb_fetch_unit;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        halt;
    logic        fault;
    logic [31:0] fetch_count;

    fetch_unit #(.RESET_PC(32'h0), .IM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .instr_in(instr_in),
        .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .branch_imm(branch_imm), .jump_index(jump_index), .jr_target(jr_target),
        .halt(halt), .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];

    always_comb begin
        if (pc_out[31:10] == 22'd0) instr_in = mem[pc_out[9:2]];
        else                        instr_in = 32'hBAD0_BAD0;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_ir, m_irpc, m_count;
    logic        m_valid, m_fault, m_halted;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".pc_out"}, pc_out, m_pc);
        check_val({tag, ".ir_out"}, ir_out, m_ir);
        check_val({tag, ".ir_pc"}, ir_pc, m_irpc);
        check_val({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
        check_val({tag, ".fault"}, 32'(fault), 32'(m_fault));
        check_val({tag, ".fetch_count"}, fetch_count, m_count);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr / 4 < DEPTH) return mem[addr / 4];
        return 32'hBAD0_BAD0;
    endfunction

    // Next architectural state from the current one and this cycle's inputs.
    task automatic model_step();
        logic        xfer;
        logic [31:0] tgt;
        logic [31:0] nxt;
        int          off;
        xfer = m_valid && ir_ready;
        if (m_halted) begin
            if (xfer) m_valid = 1'b0;
        end else if (xfer && redirect_valid) begin
            off = int'($signed(branch_imm)) * 4;
            case (redirect_sel)
                2'd0:    tgt = m_irpc + 32'd4 + 32'(off);
                2'd1:    tgt = ((m_irpc + 32'd4) & 32'hF000_0000) | (32'(jump_index) * 4);
                default: tgt = jr_target;
            endcase
            m_valid = 1'b0;
            if (tgt % 4 == 0 && tgt / 4 < DEPTH && redirect_sel != 2'd3) begin
                m_pc = tgt;
                if (halt) m_halted = 1'b1;
            end else begin
                m_fault  = 1'b1;
                m_halted = 1'b1;
            end
        end else if (halt) begin
            if (xfer) m_valid = 1'b0;
            m_halted = 1'b1;
        end else if (!m_valid || xfer) begin
            m_ir    = mem_word(m_pc);
            m_irpc  = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 1;
            nxt     = m_pc + 32'd4;
            if (nxt / 4 < DEPTH) m_pc = nxt;
            else begin
                m_fault  = 1'b1;
                m_halted = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [1:0] sel,
                        input logic [15:0] imm, input logic [25:0] jidx,
                        input logic [31:0] jrt, input logic hlt, input string tag);
        ir_ready       = rdy;
        redirect_valid = rv;
        redirect_sel   = sel;
        branch_imm     = imm;
        jump_index     = jidx;
        jr_target      = jrt;
        halt           = hlt;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        m_pc     = 32'h0;
        m_ir     = 32'h0;
        m_irpc   = 32'h0;
        m_count  = 32'h0;
        m_valid  = 1'b0;
        m_fault  = 1'b0;
        m_halted = 1'b0;
        compare_all("reset");
    endtask

    task automatic seq(input logic rdy, input string tag);
        step(rdy, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 1'b0, tag);
    endtask

    initial begin
        logic        rdy, rv, hlt;
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] jrt;
        int          d, r;

        reset = 1'b1; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_sel = 2'd0;
        branch_imm = 16'h0; jump_index = 26'h0; jr_target = 32'h0; halt = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        @(negedge clk);

        // straight-line fetch, one word per cycle
        apply_reset();
        check_val("rst_pc_const", pc_out, 32'h0);
        check_val("rst_valid_const", 32'(ir_valid), 32'h0);
        for (int i = 0; i < 4; i++) seq(1'b1, "stream");
        check_val("stream_ir_const", ir_out, 32'h44);
        check_val("stream_irpc_const", ir_pc, 32'hC);
        check_val("stream_count_const", fetch_count, 32'd4);

        // stall while decode is not ready
        apply_reset();
        seq(1'b1, "stall_fill");
        seq(1'b1, "stall_fill");
        for (int i = 0; i < 3; i++) seq(1'b0, "stall_hold");
        check_val("stall_ir_const", ir_out, 32'h22);
        check_val("stall_pc_const", pc_out, 32'h8);
        seq(1'b1, "stall_resume");
        check_val("resume_ir_const", ir_out, 32'h33);

        // backward branch from ir_pc 0x10
        seq(1'b1, "pre_branch");
        seq(1'b1, "pre_branch");
        check_val("branch_src_irpc", ir_pc, 32'h10);
        step(1'b1, 1'b1, 2'd0, 16'hFFFE, 26'h0, 32'h0, 1'b0, "branch");
        check_val("branch_pc_const", pc_out, 32'hC);
        check_val("branch_bubble_const", 32'(ir_valid), 32'h0);
        seq(1'b1, "branch_land");
        check_val("branch_land_irpc", ir_pc, 32'hC);

        // misaligned jr target faults
        step(1'b1, 1'b1, 2'd2, 16'h0, 26'h0, 32'h402, 1'b0, "jr_bad");
        check_val("jr_bad_fault_const", 32'(fault), 32'h1);
        check_val("jr_bad_pc_const", pc_out, 32'h10);
        for (int i = 0; i < 3; i++) seq(1'b1, "jr_bad_idle");
        check_val("jr_bad_idle_valid", 32'(ir_valid), 32'h0);

        // last word of memory: loaded, then fault
        apply_reset();
        seq(1'b1, "edge_fill");
        step(1'b1, 1'b1, 2'd2, 16'h0, 26'h0, 32'h3FC, 1'b0, "edge_jr");
        seq(1'b1, "edge_load");
        check_val("edge_irpc_const", ir_pc, 32'h3FC);
        check_val("edge_pc_const", pc_out, 32'h3FC);
        check_val("edge_fault_const", 32'(fault), 32'h1);
        seq(1'b1, "edge_drain");

        // halt with a pending IR
        apply_reset();
        seq(1'b1, "halt_fill");
        step(1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0, 1'b1, "halt_req");
        check_val("halt_offer_valid", 32'(ir_valid), 32'h1);
        seq(1'b0, "halt_wait");
        seq(1'b1, "halt_drain");
        for (int i = 0; i < 3; i++) seq(1'b1, "halt_idle");
        check_val("halt_pc_const", pc_out, 32'h4);
        check_val("halt_count_const", fetch_count, 32'd1);
        apply_reset();
        check_val("halt_reset_pc", pc_out, 32'h0);

        // randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            apply_reset();
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(299) == 0) apply_reset();
                rdy = ($urandom_range(3) != 0);
                rv  = ($urandom_range(4) == 0);
                r   = int'($urandom_range(15));
                sel = (r < 7) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
                d   = int'($urandom_range(40)) - 20;
                imm = d[15:0];
                jidx = ($urandom_range(7) == 0) ? 26'($urandom) : 26'($urandom_range(255));
                r   = int'($urandom_range(9));
                if (r == 0)      jrt = $urandom;
                else if (r == 1) jrt = (32'($urandom_range(255)) * 4) + 32'd1;
                else             jrt = 32'($urandom_range(255)) * 4;
                hlt = ($urandom_range(199) == 0);
                step(rdy, rv, sel, imm, jidx, jrt, hlt, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
